// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbitration slice: requester count,
// owner index width, grant-controller state encoding and a one-hot
// to index helper.
package bus_arb_pkg;

    localparam int unsigned NREQ = 3;
    localparam int unsigned ID_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } grant_state_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [ID_W-1:0] onehot_to_idx(input logic [NREQ-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int unsigned i = NREQ; i > 0; i--) begin
            if (vec[i-1]) begin
                idx = ID_W'(i - 1);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/grant_hold_timer.sv
// Saturating hold counter for the grant watchdog. Counts cycles while
// enabled, is held at zero while cleared, and flags the last permitted
// grant cycle (count == MAX_HOLD-1).
module grant_hold_timer #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count;

    // Clear has priority; otherwise count up while enabled, stopping at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == 8'(MAX_HOLD - 1));

endmodule

// File: rtl/bus_grant_ctrl.sv
// Registered, locked bus grant built on top of the combinational
// fixed-priority arbiter. An owner keeps the bus until it strobes done
// or drops its request, then one dead turnaround cycle follows.
// Optional watchdog revocation is enabled by defining BUS_GRANT_TIMEOUT_EN.
module bus_grant_ctrl
    import bus_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  gnt_in,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  done,
    output logic [NREQ-1:0]  gnt,
    output logic [ID_W-1:0]  owner,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic             timeout
);

    grant_state_t    state;
    logic [NREQ-1:0] gnt_pick;
    logic            release_now;

    // Isolate the lowest set bit so an illegal multi-hot grant still
    // yields a one-hot ownership.
    always_comb begin
        gnt_pick = gnt_in & (~gnt_in + NREQ'(1));
    end

    // gnt is one-hot for the owner while in GRANT, so masking with it
    // selects done[owner] and req[owner] without an indexed select.
    always_comb begin
        release_now = (|(gnt & done)) || !(|(gnt & req));
    end

`ifdef BUS_GRANT_TIMEOUT_EN
    logic hold_expired;
    logic hold_clr;
    logic hold_en;

    always_comb begin
        hold_clr = (state != GRANT);
        hold_en  = (state == GRANT);
    end

    grant_hold_timer #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (hold_clr),
        .en      (hold_en),
        .expired (hold_expired)
    );
`else
    assign timeout = 1'b0;
`endif

    // Ownership FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            xfer_cnt <= '0;
`ifdef BUS_GRANT_TIMEOUT_EN
            timeout  <= 1'b0;
`endif
        end else begin
`ifdef BUS_GRANT_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (gnt_in != '0) begin
                        gnt   <= gnt_pick;
                        owner <= onehot_to_idx(gnt_in);
                        busy  <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt      <= '0;
                        busy     <= 1'b0;
                        xfer_cnt <= xfer_cnt + CNT_W'(1);
                        state    <= TURN;
                    end
`ifdef BUS_GRANT_TIMEOUT_EN
                    else if (hold_expired) begin
                        gnt     <= '0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                        state   <= TURN;
                    end
`endif
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_grant_ctrl.sv
// Self-checking bench for bus_grant_ctrl: directed vector table,
// hand-written reset/watchdog sequences and randomized traffic checked
// against a behavioural ownership model.
module tb_bus_grant_ctrl;

    localparam int unsigned CNT_W    = 2;
    localparam int unsigned MAX_HOLD = 4;
`ifdef BUS_GRANT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [2:0]       gnt_in = '0;
    logic [2:0]       req = '0;
    logic [2:0]       done = '0;
    logic [2:0]       gnt;
    logic [1:0]       owner;
    logic             busy;
    logic [CNT_W-1:0] xfer_cnt;
    logic             timeout;

    int total = 0;
    int bad   = 0;

    bus_grant_ctrl #(
        .NREQ     (3),
        .CNT_W    (CNT_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .gnt_in   (gnt_in),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .owner    (owner),
        .busy     (busy),
        .xfer_cnt (xfer_cnt),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    // Behavioural model: who owns the bus (-1 = nobody), whether the
    // turnaround gap is pending, how long the owner has held it.
    int m_own;
    int m_last;
    bit m_gap;
    int m_held;
    int m_cnt;
    bit m_to;

    typedef struct {
        logic [2:0] gi;
        logic [2:0] rq;
        logic [2:0] dn;
        logic [2:0] eg;
        logic [1:0] eo;
        logic       eb;
        logic [1:0] ec;
        logic       et;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] eg, input logic [1:0] eo,
                             input logic eb, input logic [1:0] ec, input logic et);
        check({tag, ".gnt"},      32'(gnt),      32'(eg));
        check({tag, ".owner"},    32'(owner),    32'(eo));
        check({tag, ".busy"},     32'(busy),     32'(eb));
        check({tag, ".xfer_cnt"}, 32'(xfer_cnt), 32'(ec));
        check({tag, ".timeout"},  32'(timeout),  32'(et));
    endtask

    function automatic int lowest(input logic [2:0] v);
        for (int i = 0; i < 3; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_own  = -1;
        m_last = 0;
        m_gap  = 1'b0;
        m_held = 0;
        m_cnt  = 0;
        m_to   = 1'b0;
    endtask

    task automatic model_step();
        m_to = 1'b0;
        if (m_own >= 0) begin
            if (done[m_own] || !req[m_own]) begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                m_own = -1;
                m_gap = 1'b1;
            end else if (TO_EN && (m_held + 1 >= MAX_HOLD)) begin
                m_own = -1;
                m_gap = 1'b1;
                m_to  = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (gnt_in != 3'b000) begin
            m_own  = lowest(gnt_in);
            m_last = m_own;
            m_held = 0;
        end
    endtask

    task automatic model_compare(input string tag);
        logic [2:0] eg;
        eg = (m_own >= 0) ? 3'(1 << m_own) : 3'b000;
        check_all(tag, eg, 2'(m_last), (m_own >= 0), 2'(m_cnt), m_to);
    endtask

    task automatic model_cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        model_compare(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        gnt_in = '0;
        req    = '0;
        done   = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [2:0] r;

        tbl[0]  = '{3'b010, 3'b110, 3'b000, 3'b010, 2'd1, 1'b1, 2'd0, 1'b0};
        tbl[1]  = '{3'b001, 3'b111, 3'b000, 3'b010, 2'd1, 1'b1, 2'd0, 1'b0};
        tbl[2]  = '{3'b001, 3'b111, 3'b100, 3'b010, 2'd1, 1'b1, 2'd0, 1'b0};
        tbl[3]  = '{3'b001, 3'b111, 3'b010, 3'b000, 2'd1, 1'b0, 2'd1, 1'b0};
        tbl[4]  = '{3'b001, 3'b111, 3'b000, 3'b000, 2'd1, 1'b0, 2'd1, 1'b0};
        tbl[5]  = '{3'b001, 3'b111, 3'b000, 3'b001, 2'd0, 1'b1, 2'd1, 1'b0};
        tbl[6]  = '{3'b100, 3'b101, 3'b000, 3'b001, 2'd0, 1'b1, 2'd1, 1'b0};
        tbl[7]  = '{3'b100, 3'b100, 3'b000, 3'b000, 2'd0, 1'b0, 2'd2, 1'b0};
        tbl[8]  = '{3'b100, 3'b100, 3'b000, 3'b000, 2'd0, 1'b0, 2'd2, 1'b0};
        tbl[9]  = '{3'b100, 3'b100, 3'b100, 3'b100, 2'd2, 1'b1, 2'd2, 1'b0};
        tbl[10] = '{3'b100, 3'b100, 3'b001, 3'b100, 2'd2, 1'b1, 2'd2, 1'b0};
        tbl[11] = '{3'b000, 3'b000, 3'b100, 3'b000, 2'd2, 1'b0, 2'd3, 1'b0};
        tbl[12] = '{3'b110, 3'b110, 3'b000, 3'b000, 2'd2, 1'b0, 2'd3, 1'b0};
        tbl[13] = '{3'b110, 3'b110, 3'b000, 3'b010, 2'd1, 1'b1, 2'd3, 1'b0};
        tbl[14] = '{3'b000, 3'b110, 3'b010, 3'b000, 2'd1, 1'b0, 2'd0, 1'b0};
        tbl[15] = '{3'b000, 3'b000, 3'b000, 3'b000, 2'd1, 1'b0, 2'd0, 1'b0};
        tbl[16] = '{3'b000, 3'b000, 3'b000, 3'b000, 2'd1, 1'b0, 2'd0, 1'b0};

        // Asynchronous reset mid-cycle, no clock edge in between.
        #3;
        rst = 1'b1;
        #1;
        check_all("rst_async", 3'b000, 2'd0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table: grant, lock, turnaround, foreign done,
        // request drop, combined done+drop, multi-hot grant, count wrap.
        for (int i = 0; i < 17; i++) begin
            gnt_in = tbl[i].gi;
            req    = tbl[i].rq;
            done   = tbl[i].dn;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), tbl[i].eg, tbl[i].eo, tbl[i].eb, tbl[i].ec, tbl[i].et);
        end

        // Reset mid-grant: complete one transfer, take a new grant, reset.
        gnt_in = 3'b001; req = 3'b001; done = 3'b000;
        @(posedge clk); #1;
        done = 3'b001;
        @(posedge clk); #1;
        done = 3'b000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_all("pre_rst_grant", 3'b001, 2'd0, 1'b1, 2'd1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_all("rst_mid_grant", 3'b000, 2'd0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        gnt_in = 3'b100; req = 3'b100;
        @(posedge clk); #1;
        check_all("post_rst_grant", 3'b100, 2'd2, 1'b1, 2'd0, 1'b0);

        // Long hold with no done: revoked by the watchdog or held forever.
        do_reset();
        gnt_in = 3'b001; req = 3'b001; done = 3'b000;
        for (int i = 1; i <= 100; i++) begin
            model_cycle($sformatf("hold%0d", i));
            if (i == 5) begin
                if (TO_EN) check_all("hold_revoke", 3'b000, 2'd0, 1'b0, 2'd0, 1'b1);
                else       check_all("hold_keep5", 3'b001, 2'd0, 1'b1, 2'd0, 1'b0);
            end
        end
        if (!TO_EN) check_all("hold_keep100", 3'b001, 2'd0, 1'b1, 2'd0, 1'b0);

        // Randomized traffic against the model; requests are sticky so
        // grants last several cycles. Occasional illegal multi-hot gnt_in.
        do_reset();
        r = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            req = r;
            if ($urandom_range(0, 9) == 0) gnt_in = 3'($urandom_range(0, 7));
            else                           gnt_in = r & (~r + 3'd1);
            done = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            model_cycle($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_grant_ctrl.md
Name: bus_grant_ctrl

Overview:
- Sits directly downstream of the 3-request fixed-priority arbiter.
- The arbiter's combinational one-hot grant is turned into a registered, locked bus ownership.
  - The owner keeps the bus until it signals done or drops its request.
  - A one-cycle turnaround gap follows each release.
- Also provides the owner index, a busy flag and a completed-transfer count for the downstream bus mux.

Parameters:
- NREQ, 3: number of requesters; must match the arbiter width.
- CNT_W, 8: width of the completed-transfer counter.
- MAX_HOLD, 16: maximum grant length in cycles, used only with the optional watchdog. Legal range 2..255.

Ports:
- clk  input  1  single rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- gnt_in  input  NREQ  one-hot grant from the arbiter (combinational, r[0] highest priority).
- req  input  NREQ  raw request lines, same vector the arbiter sees.
- done  input  NREQ  per-master end-of-transfer strobe; only the owner's bit is honoured.
- gnt  output  NREQ  registered, locked one-hot grant.
- owner  output  2  index of the current owner; valid while busy=1.
- busy  output  1  high while any grant is held.
- xfer_cnt  output  CNT_W  number of completed grants; wraps modulo 2^CNT_W.
- timeout  output  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset (async, rst=1): state=IDLE; gnt=0, owner=0, busy=0, xfer_cnt=0, timeout=0; hold counter=0. All outputs are registered.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If gnt_in != 0, latch it into gnt on the next edge, set owner = index of the bit, busy=1, and go to GRANT.
  - If gnt_in has more than one bit set (illegal), the lowest index wins.
  - Latency is one cycle from gnt_in to gnt.
  - done is ignored in IDLE.
- GRANT:
  - gnt is frozen; changes on gnt_in are ignored (no preemption).
  - Exit to TURN when done[owner]=1 or req[owner]=0. On that edge gnt=0, busy=0, xfer_cnt+=1.
  - done on non-owner bits is ignored.
  - If done[owner] and req[owner]=0 occur together, count once.
- TURN:
  - Exactly one dead cycle with gnt=0; no sampling of gnt_in. Then go to IDLE.
  - A master that releases at edge N sees gnt drop at N+1; the earliest new grant is at N+3 (TURN at N+1→N+2, IDLE samples at N+2).
- Hold counter:
  - Cleared on entry to GRANT; increments every GRANT cycle; saturates at 255.
  - Used only by the watchdog.
- xfer_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- owner holds its last value outside GRANT.
- A reset asserted mid-grant drops gnt immediately (asynchronously); the interrupted transfer is not counted.

Optional Feature:
- Macro: BUS_GRANT_TIMEOUT_EN.
- Defined:
  - If the hold counter reaches MAX_HOLD-1 in GRANT without an exit condition, force TURN on the next edge.
  - On that edge: gnt=0, busy=0, timeout=1 for one cycle, xfer_cnt NOT incremented.
  - A normal exit in the same cycle as the timeout condition takes precedence: counted, no timeout.
- Undefined:
  - No revocation; a grant is held indefinitely.
  - The timeout port remains and is tied to 0; the hold counter is removed.

Decomposition:
- Shared package bus_arb_pkg:
  - NREQ and ID_W (=2) constants.
  - State enum typedef (IDLE=2'd0, GRANT=2'd1, TURN=2'd2).
  - onehot_to_idx function (lowest set bit).
- One sub-module, grant_hold_timer:
  - Clear/enable saturating counter with a compare-to-MAX_HOLD output.
  - Instantiated only under BUS_GRANT_TIMEOUT_EN.

Test Plan:
- Reset and first grant: rst pulse mid-cycle → all outputs 0 asynchronously. Then req=3'b110, gnt_in=3'b010 → next edge gnt=3'b010, owner=1, busy=1.
- Lock: while owner=1, drive gnt_in=3'b001 and req=3'b111 → gnt stays 3'b010. done=3'b010 → gnt=0 next edge, xfer_cnt=1, then after the TURN cycle gnt=3'b001.
- Foreign done and request drop: owner=2, pulse done=3'b001 → no change. Drop req[2] → release, xfer_cnt increments.
- Counter wrap: CNT_W=2, complete 4 grants → xfer_cnt sequence 1,2,3,0.
- Reset mid-grant: assert rst while busy=1 → gnt=0, xfer_cnt=0, state IDLE; after release, a new grant follows on the next request.
- Watchdog (BUS_GRANT_TIMEOUT_EN, MAX_HOLD=4): hold a grant with no done → gnt drops after 4 GRANT cycles, timeout=1 for one cycle, xfer_cnt unchanged. Without the macro, the same stimulus holds the grant for 100 cycles with timeout=0.
